// File: rtl/bsg_axi_to_sram_slave_if.sv
// AXI AW/W/B/AR/R channels plus the single-port SRAM port serviced by
// bsg_axi_to_sram_slave.
interface bsg_axi_to_sram_slave_if #(
    parameter int axi_id_width_p   = 1,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 128,
    parameter int mem_els_p        = 1024
);
    localparam int strb_w = axi_data_width_p / 8;
    localparam int word_w = $clog2(mem_els_p);

    logic [axi_id_width_p-1:0]   awid;
    logic [axi_addr_width_p-1:0] awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [axi_data_width_p-1:0] wdata;
    logic [strb_w-1:0]           wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        wready;
    logic [axi_id_width_p-1:0]   bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [axi_id_width_p-1:0]   arid;
    logic [axi_addr_width_p-1:0] araddr;
    logic                        arvalid;
    logic                        arready;
    logic [axi_id_width_p-1:0]   rid;
    logic [axi_data_width_p-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;
    logic                        mem_v;
    logic                        mem_w;
    logic [word_w-1:0]           mem_addr;
    logic [axi_data_width_p-1:0] mem_wdata;
    logic [strb_w-1:0]           mem_mask;
    logic [axi_data_width_p-1:0] mem_rdata;

    modport slave (
        input  awid, awaddr, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        output mem_v, mem_w, mem_addr, mem_wdata, mem_mask, input mem_rdata
    );

    modport master (
        output awid, awaddr, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        input  mem_v, mem_w, mem_addr, mem_wdata, mem_mask, output mem_rdata
    );
endinterface

// File: rtl/bsg_axi_to_sram_slave.sv
// One-transaction-at-a-time AXI slave backed by a single-port synchronous SRAM.
// Optional out-of-range checking is enabled with `define BSG_AXI_SRAM_RANGE_CHECK_EN.
module bsg_axi_to_sram_slave #(
    parameter int axi_id_width_p   = 1,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 128,
    parameter int axi_burst_len_p  = 2,
    parameter int mem_els_p        = 1024
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bsg_axi_to_sram_slave_if.slave bus
);
    localparam int strb_w = axi_data_width_p / 8;
    localparam int word_w = $clog2(mem_els_p);
    localparam int off_w  = $clog2(strb_w);
`ifdef BSG_AXI_SRAM_RANGE_CHECK_EN
    localparam int full_w = axi_addr_width_p - off_w;
    // Keep the full beat index so that a start or crossing beyond the SRAM shows up in the high bits.
    localparam int cnt_w  = (full_w > word_w) ? full_w : word_w;
`else
    localparam int cnt_w  = word_w;
`endif
    localparam int beat_w = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RWAIT, RDATA} state_e;

    state_e                      state_r, state_n;
    logic [cnt_w-1:0]            word_r;
    logic [beat_w-1:0]           beat_r;
    logic [axi_id_width_p-1:0]   awid_r, arid_r;
    logic [axi_data_width_p-1:0] rdata_r;
    logic                        werr_r, rerr_r;
    logic                        oor;
    logic                        last_beat;
    logic [cnt_w-1:0]            aw_word, ar_word;

    assign aw_word   = cnt_w'(bus.awaddr >> off_w);
    assign ar_word   = cnt_w'(bus.araddr >> off_w);
    assign oor       = (cnt_w > word_w) ? ((word_r >> word_w) != '0) : 1'b0;
    assign last_beat = (beat_r == beat_w'(axi_burst_len_p - 1));

    always_comb begin
        state_n       = state_r;
        bus.awready   = 1'b0;
        bus.arready   = 1'b0;
        bus.wready    = 1'b0;
        bus.bvalid    = 1'b0;
        bus.rvalid    = 1'b0;
        bus.bid       = awid_r;
        bus.bresp     = werr_r ? 2'b10 : 2'b00;
        bus.rid       = arid_r;
        bus.rdata     = rdata_r;
        bus.rresp     = rerr_r ? 2'b10 : 2'b00;
        bus.rlast     = last_beat;
        bus.mem_v     = 1'b0;
        bus.mem_w     = 1'b0;
        bus.mem_addr  = word_r[word_w-1:0];
        bus.mem_wdata = bus.wdata;
        bus.mem_mask  = bus.wstrb;
        // Async reset also masks every handshake output while it is held.
        if (!reset_i) begin
            unique case (state_r)
                IDLE: begin
                    bus.awready = 1'b1;
                    bus.arready = !bus.awvalid;
                    if (bus.awvalid)      state_n = WDATA;
                    else if (bus.arvalid) state_n = RREQ;
                end
                WDATA: begin
                    bus.wready = 1'b1;
                    bus.mem_v  = bus.wvalid && !oor;
                    bus.mem_w  = bus.wvalid;
                    if (bus.wvalid && bus.wlast) state_n = WRESP;
                end
                WRESP: begin
                    bus.bvalid = 1'b1;
                    if (bus.bready) state_n = IDLE;
                end
                RREQ: begin
                    bus.mem_v = !oor;
                    state_n   = RWAIT;
                end
                RWAIT: state_n = RDATA;
                RDATA: begin
                    bus.rvalid = 1'b1;
                    if (bus.rready) state_n = last_beat ? IDLE : RREQ;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            word_r  <= '0;
            beat_r  <= '0;
            awid_r  <= '0;
            arid_r  <= '0;
            rdata_r <= '0;
            werr_r  <= 1'b0;
            rerr_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            unique case (state_r)
                IDLE: begin
                    if (bus.awvalid) begin
                        awid_r <= bus.awid;
                        word_r <= aw_word;
                        werr_r <= 1'b0;
                    end else if (bus.arvalid) begin
                        arid_r <= bus.arid;
                        word_r <= ar_word;
                        beat_r <= '0;
                    end
                end
                WDATA: begin
                    if (bus.wvalid) begin
                        word_r <= word_r + 1'b1;
                        if (oor) werr_r <= 1'b1;
                    end
                end
                RREQ:  rerr_r  <= oor;
                RWAIT: rdata_r <= rerr_r ? '0 : bus.mem_rdata;
                RDATA: begin
                    if (bus.rready && !last_beat) begin
                        beat_r <= beat_r + 1'b1;
                        word_r <= word_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_axi_to_sram_slave.sv
// Self-checking bench for bsg_axi_to_sram_slave: table of write/read-back
// vectors plus hand-written collision, stall, byte-strobe and reset sequences.
module tb_bsg_axi_to_sram_slave;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int BL     = 2;
    localparam int ELS    = 1024;
    localparam int STRB_W = DATA_W / 8;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    bsg_axi_to_sram_slave_if #(.axi_id_width_p(ID_W), .axi_addr_width_p(ADDR_W),
                               .axi_data_width_p(DATA_W), .mem_els_p(ELS)) bus ();

    bsg_axi_to_sram_slave #(.axi_id_width_p(ID_W), .axi_addr_width_p(ADDR_W),
                            .axi_data_width_p(DATA_W), .axi_burst_len_p(BL),
                            .mem_els_p(ELS)) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    // SRAM model: masked write, registered read
    logic [DATA_W-1:0] sram [ELS];
    always @(posedge clk) begin
        if (bus.mem_v) begin
            if (bus.mem_w) begin
                for (int b = 0; b < STRB_W; b++)
                    if (bus.mem_mask[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= sram[bus.mem_addr];
            end
        end
    end

    typedef struct { logic [9:0] addr; logic [DATA_W-1:0] data; logic [STRB_W-1:0] mask; } wr_t;
    typedef struct { logic [DATA_W-1:0] data; logic last; logic [ID_W-1:0] id; logic [1:0] resp; } rd_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [ID_W-1:0] id; logic [ADDR_W-1:0] addr; int n;
                     logic [DATA_W-1:0] d0; logic [STRB_W-1:0] strb; logic [1:0] bresp; } vec_t;

    logic [DATA_W-1:0] ref_mem [ELS];
    wr_t wr_q[$];
    rd_t rd_q[$];
    b_t  b_q[$];
    vec_t vt[5];

    int checks = 0, errors = 0, cyc = 0, r_hs_cnt = 0, ar_hs_cnt = 0;
    logic s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
    logic s_rvalid, s_bvalid, s_rlast, s_arready, s_awready, s_mem_v;
    logic [DATA_W-1:0] s_rdata;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [DATA_W-1:0] act);
        checks++;
        errors++;
        $display("FAIL %s: actual=%0h required=none", name, act);
    endtask

    task automatic monitor();
        s_aw_hs   = bus.awvalid && bus.awready;
        s_w_hs    = bus.wvalid && bus.wready;
        s_b_hs    = bus.bvalid && bus.bready;
        s_ar_hs   = bus.arvalid && bus.arready;
        s_r_hs    = bus.rvalid && bus.rready;
        s_rvalid  = bus.rvalid;
        s_bvalid  = bus.bvalid;
        s_rlast   = bus.rlast;
        s_rdata   = bus.rdata;
        s_arready = bus.arready;
        s_awready = bus.awready;
        s_mem_v   = bus.mem_v;
        if (bus.mem_v && bus.mem_w) begin
            if (wr_q.size() == 0) fail_now("memwr_unexpected", {118'd0, bus.mem_addr});
            else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("memwr_addr", bus.mem_addr, e.addr);
                chk("memwr_data", bus.mem_wdata, e.data);
                chk("memwr_mask", bus.mem_mask, e.mask);
            end
        end
        if (s_ar_hs) ar_hs_cnt++;
        if (s_r_hs) begin
            r_hs_cnt++;
            if (rd_q.size() == 0) fail_now("r_unexpected", bus.rdata);
            else begin
                rd_t e;
                e = rd_q.pop_front();
                chk("r_data", bus.rdata, e.data);
                chk("r_last", bus.rlast, e.last);
                chk("r_id", bus.rid, e.id);
                chk("r_resp", bus.rresp, e.resp);
            end
        end
        if (s_b_hs) begin
            if (b_q.size() == 0) fail_now("b_unexpected", bus.bid);
            else begin
                b_t e;
                e = b_q.pop_front();
                chk("b_id", bus.bid, e.id);
                chk("b_resp", bus.bresp, e.resp);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int n,
                         input logic [DATA_W-1:0] d0, input logic [STRB_W-1:0] strb, input logic [1:0] resp);
        int w, idx, g;
        logic [DATA_W-1:0] dv;
        wr_t e;
        w = int'(addr >> 4);
        for (int i = 0; i < n; i++) begin
            idx = (w + i) % ELS;
            dv = d0 + DATA_W'(i);
            e.addr = idx[9:0]; e.data = dv; e.mask = strb;
            wr_q.push_back(e);
            for (int b = 0; b < STRB_W; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = dv[8*b +: 8];
        end
        b_q.push_back('{id, resp});
        bus.awid = id; bus.awaddr = addr; bus.awvalid = 1'b1;
        g = 0;
        do begin step(); g++; end while (!s_aw_hs && g < 50);
        if (!s_aw_hs) fail_now("aw_timeout", addr);
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input int n, input logic [DATA_W-1:0] d0, input logic [STRB_W-1:0] strb);
        int g;
        for (int i = 0; i < n; i++) begin
            bus.wvalid = 1'b1; bus.wdata = d0 + DATA_W'(i); bus.wstrb = strb; bus.wlast = (i == n - 1);
            g = 0;
            do begin step(); g++; end while (!s_w_hs && g < 50);
            if (!s_w_hs) fail_now("w_timeout", i);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic do_b();
        int g;
        bus.bready = 1'b0;
        step();
        chk("b_latency_bvalid", s_bvalid, 1'b1);
        bus.bready = 1'b1;
        g = 0;
        do begin step(); g++; end while (!s_b_hs && g < 50);
        if (!s_b_hs) fail_now("b_timeout", g);
        bus.bready = 1'b0;
    endtask

    task automatic do_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input bit push);
        int w, g;
        w = int'(addr >> 4);
        if (push)
            for (int i = 0; i < BL; i++)
                rd_q.push_back('{ref_mem[(w + i) % ELS], (i == BL - 1), id, 2'b00});
        bus.arid = id; bus.araddr = addr; bus.arvalid = 1'b1;
        g = 0;
        do begin step(); g++; end while (!s_ar_hs && g < 50);
        if (!s_ar_hs) fail_now("ar_timeout", addr);
        bus.arvalid = 1'b0;
    endtask

    task automatic do_r(input int stall);
        int lat, g, start, last_c;
        logic [DATA_W-1:0] hold_d;
        logic hold_l;
        start = r_hs_cnt;
        bus.rready = (stall == 0);
        lat = 0;
        do begin step(); lat++; end while (!s_rvalid && lat < 20);
        chk("r_first_latency", lat, 3);
        last_c = cyc;
        if (stall > 0) begin
            hold_d = s_rdata; hold_l = s_rlast;
            for (int k = 0; k < stall; k++) begin
                step();
                chk("stall_rvalid", s_rvalid, 1'b1);
                chk("stall_rdata", s_rdata, hold_d);
                chk("stall_rlast", s_rlast, hold_l);
                chk("stall_no_mem_access", s_mem_v, 1'b0);
            end
            bus.rready = 1'b1;
        end
        g = 0;
        while (r_hs_cnt - start < BL && g < 60) begin
            step(); g++;
            if (s_r_hs && stall == 0) begin
                chk("r_beat_spacing", cyc - last_c, 3);
                last_c = cyc;
            end
        end
        chk("r_beat_count", r_hs_cnt - start, BL);
        bus.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int arcnt0;
        int g;
        bit any_rv;
        reset_i = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        vt[0] = '{4'd3,  32'h40,   2, {32'hAAAA_0000, 32'h1111_2222, 32'h3333_4444, 32'h5555_0000}, 16'hFFFF, 2'b00};
        vt[1] = '{4'd5,  32'h200,  4, {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h0123_4567, 32'h89AB_0000}, 16'hFFFF, 2'b00};
        vt[2] = '{4'd0,  32'h1234, 2, {32'h7777_8888, 32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_0000}, 16'hFFFF, 2'b00};
        vt[3] = '{4'd15, 32'h200,  2, {32'h1357_9BDF, 32'h2468_ACE0, 32'hFEDC_BA98, 32'h7654_3210}, 16'h00F0, 2'b00};
`ifdef BSG_AXI_SRAM_RANGE_CHECK_EN
        vt[4] = '{4'd9,  32'h3FE0, 2, {32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hF0F0_0000}, 16'hFFFF, 2'b00};
`else
        vt[4] = '{4'd9,  32'h3FF0, 2, {32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hF0F0_0000}, 16'hFFFF, 2'b00};
`endif

        #2;
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_mem_v", bus.mem_v, 1'b0);
        step(); step();
        reset_i = 1'b0;
        step();
        chk("idle_awready", s_awready, 1'b1);
        chk("idle_arready", s_arready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            do_aw(vt[i].id, vt[i].addr, vt[i].n, vt[i].d0, vt[i].strb, vt[i].bresp);
            do_w(vt[i].n, vt[i].d0, vt[i].strb);
            do_b();
            do_ar(vt[i].id, vt[i].addr, 1'b1);
            do_r(0);
        end

        // AW and AR together: AW wins, AR waits until the write response is taken
        bus.arid = 4'd7; bus.araddr = 32'h200; bus.arvalid = 1'b1;
        arcnt0 = ar_hs_cnt;
        do_aw(4'd6, 32'h200, 2, {4{32'hC0DE_0001}}, 16'hFFFF, 2'b00);
        chk("collision_arready", s_arready, 1'b0);
        do_w(2, {4{32'hC0DE_0001}}, 16'hFFFF);
        do_b();
        chk("collision_ar_held", ar_hs_cnt - arcnt0, 0);
        do_ar(4'd7, 32'h200, 1'b1);
        do_r(0);

        // rready held low for 5 cycles in RDATA
        do_ar(4'd2, 32'h40, 1'b1);
        do_r(5);

        // partial byte strobe over an all-ones word
        do_aw(4'd1, 32'h0F0, 2, {{127{1'b1}}, 1'b0}, 16'hFFFF, 2'b00);
        do_w(2, {{127{1'b1}}, 1'b0}, 16'hFFFF);
        do_b();
        do_aw(4'd1, 32'h100, 1, {96'd0, 32'hDEAD_BEEF}, 16'h000F, 2'b00);
        do_w(1, {96'd0, 32'hDEAD_BEEF}, 16'h000F);
        do_b();
        chk("strb_word", sram[16], {{96{1'b1}}, 32'hDEAD_BEEF});
        do_ar(4'd1, 32'h0F0, 1'b1);
        do_r(0);

        // reset while in RDATA abandons the burst
        do_ar(4'd4, 32'h40, 1'b1);
        bus.rready = 1'b0;
        g = 0;
        do begin step(); g++; end while (!s_rvalid && g < 20);
        chk("pre_reset_rvalid", s_rvalid, 1'b1);
        reset_i = 1'b1;
        #1;
        chk("midrst_rvalid", bus.rvalid, 1'b0);
        chk("midrst_arready", bus.arready, 1'b0);
        chk("midrst_awready", bus.awready, 1'b0);
        chk("midrst_mem_v", bus.mem_v, 1'b0);
        rd_q.delete();
        step(); step();
        reset_i = 1'b0;
        bus.rready = 1'b1;
        any_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            any_rv |= s_rvalid;
        end
        chk("no_replay_rvalid", any_rv, 1'b0);
        bus.rready = 1'b0;
        do_ar(4'd4, 32'h200, 1'b1);
        do_r(0);

`ifdef BSG_AXI_SRAM_RANGE_CHECK_EN
        rd_q.push_back('{'0, 1'b0, 4'd8, 2'b10});
        rd_q.push_back('{'0, 1'b1, 4'd8, 2'b10});
        do_ar(4'd8, 32'(ELS) << 4, 1'b0);
        do_r(0);
`endif

        step();
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("b_q_drained", b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
